l1_wb_loader: RTL and testbench

//  Wishbone initiator that drives the L1 trigger register space (thresholds, subthresholds, scalers).

---
 rtl/l1_wb_loader.sv | 220 ++++++++++++++++++++++
 tb/tb_l1_wb_loader.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_wb_loader.sv
// Wishbone initiator for the L1 trigger register space: loads per-beam
// {subthreshold,threshold} pairs with a commit write, or dumps all scalers to a stream.
module l1_wb_loader #(
   parameter int NBEAMS      = 2,
   parameter int THRESH_BITS = 18,
   parameter int TIMEOUT     = 255
) (
   input  logic                     wb_clk_i,
   input  logic                     wb_rst_i,
   output logic                     wb_cyc_o,
   output logic                     wb_stb_o,
   output logic                     wb_we_o,
   output logic [12:0]              wb_adr_o,
   output logic [31:0]              wb_dat_o,
   output logic [3:0]               wb_sel_o,
   input  logic                     wb_ack_i,
   input  logic                     wb_err_i,
   input  logic                     wb_rty_i,
   input  logic [31:0]              wb_dat_i,
   input  logic                     load_start_i,
   input  logic                     scal_start_i,
   input  logic [2*THRESH_BITS-1:0] thr_tdata_i,
   input  logic                     thr_tvalid_i,
   output logic                     thr_tready_o,
   output logic [31:0]              scal_tdata_o,
   output logic                     scal_tuser_o,
   output logic                     scal_tlast_o,
   output logic                     scal_tvalid_o,
   input  logic                     scal_tready_i,
   output logic                     busy_o,
   output logic                     done_o,
   output logic                     err_o
);

   localparam int IW = (2*NBEAMS > 1) ? $clog2(2*NBEAMS) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_TH_WAIT, S_TH_WR, S_SUB_WR, S_COMMIT, S_RD, S_OUT, S_GAP
   } state_t;

   state_t                 state_q, state_d, ret_q, ret_d;
   logic                   cyc_q, cyc_d;
   logic [IW-1:0]          idx_q, idx_d;
   logic [7:0]             timer_q, timer_d;
   logic [THRESH_BITS-1:0] thr_q, thr_d, sub_q, sub_d;
   logic [31:0]            rdata_q, rdata_d;
   logic                   err_q, err_d, done_q, done_d;

   logic                   sub_idx, last_idx, we;
   logic [IW-1:0]          rd_beam;
   logic [12:0]            adr;
   logic [31:0]            wdat;

   // idx_q is the beam during a load and the scaler index during a dump.
   always_comb begin
      sub_idx  = (idx_q >= IW'(NBEAMS));
      last_idx = (idx_q == IW'(2*NBEAMS-1));
      rd_beam  = sub_idx ? (idx_q - IW'(NBEAMS)) : idx_q;
      adr      = 13'h0;
      wdat     = 32'h0;
      we       = 1'b0;
      case (state_q)
         S_TH_WR: begin
            we   = 1'b1;
            adr  = 13'h0800 + (13'(idx_q) << 2);
            wdat = 32'(thr_q);
         end
         S_SUB_WR: begin
            we   = 1'b1;
            adr  = 13'h0A00 + (13'(idx_q) << 2);
            wdat = 32'(sub_q);
         end
         S_COMMIT: begin
            we   = 1'b1;
            adr  = 13'h1800;
            wdat = 32'h3;
         end
         S_RD:    adr = (sub_idx ? 13'h0600 : 13'h0400) + (13'(rd_beam) << 2);
         default: ;
      endcase
   end

   // State only changes together with cyc dropping, so the bus fields can be
   // decoded from state_q and gated by cyc_q without glitching mid-cycle.
   assign wb_cyc_o      = cyc_q;
   assign wb_stb_o      = cyc_q;
   assign wb_sel_o      = {4{cyc_q}};
   assign wb_we_o       = cyc_q & we;
   assign wb_adr_o      = cyc_q ? adr : 13'h0;
   assign wb_dat_o      = (cyc_q & we) ? wdat : 32'h0;
   assign thr_tready_o  = (state_q == S_TH_WAIT);
   assign scal_tvalid_o = (state_q == S_OUT);
   assign scal_tdata_o  = rdata_q;
   assign scal_tuser_o  = (state_q == S_OUT) & sub_idx;
   assign scal_tlast_o  = (state_q == S_OUT) & last_idx;
   assign busy_o        = (state_q != S_IDLE);
   assign done_o        = done_q;
   assign err_o         = err_q;

   always_comb begin
      state_d = state_q;
      ret_d   = ret_q;
      cyc_d   = cyc_q;
      idx_d   = idx_q;
      timer_d = timer_q;
      thr_d   = thr_q;
      sub_d   = sub_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (load_start_i) begin
               state_d = S_TH_WAIT;
               idx_d   = '0;
               err_d   = 1'b0;
            end else if (scal_start_i) begin
               state_d = S_RD;
               idx_d   = '0;
               err_d   = 1'b0;
            end
         end
         S_TH_WAIT: begin
            if (thr_tvalid_i) begin
               thr_d   = thr_tdata_i[THRESH_BITS-1:0];
               sub_d   = thr_tdata_i[2*THRESH_BITS-1:THRESH_BITS];
               state_d = S_TH_WR;
            end
         end
         S_TH_WR, S_SUB_WR, S_COMMIT, S_RD: begin
            if (!cyc_q) begin
               cyc_d   = 1'b1;
               timer_d = 8'd0;
            end else begin
               timer_d = timer_q + 8'd1;
               if (wb_err_i) begin
                  cyc_d   = 1'b0;
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end else if (wb_ack_i) begin
                  cyc_d = 1'b0;
                  case (state_q)
                     S_TH_WR:  state_d = S_SUB_WR;
                     S_SUB_WR: begin
                        if (idx_q == IW'(NBEAMS-1)) begin
                           state_d = S_COMMIT;
                        end else begin
                           idx_d   = idx_q + IW'(1);
                           state_d = S_TH_WAIT;
                        end
                     end
                     S_COMMIT: begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                     end
                     default: begin
                        rdata_d = wb_dat_i;
                        state_d = S_OUT;
                     end
                  endcase
               end else if (wb_rty_i) begin
                  cyc_d   = 1'b0;
                  ret_d   = state_q;
                  state_d = S_GAP;
               end else if (timer_q == 8'(TIMEOUT-1)) begin
                  // timer_q counts cycles already spent waiting; this is cycle TIMEOUT.
                  cyc_d   = 1'b0;
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end
            end
         end
         S_OUT: begin
            if (scal_tready_i) begin
               if (last_idx) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end else begin
                  idx_d   = idx_q + IW'(1);
                  state_d = S_RD;
               end
            end
         end
         S_GAP: begin
            // One idle cycle, then reissue the identical access with a fresh timer.
            state_d = ret_q;
            cyc_d   = 1'b1;
            timer_d = 8'd0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q <= S_IDLE;
         ret_q   <= S_IDLE;
         cyc_q   <= 1'b0;
         idx_q   <= '0;
         timer_q <= 8'd0;
         thr_q   <= '0;
         sub_q   <= '0;
         rdata_q <= 32'h0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ret_q   <= ret_d;
         cyc_q   <= cyc_d;
         idx_q   <= idx_d;
         timer_q <= timer_d;
         thr_q   <= thr_d;
         sub_q   <= sub_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: tb/tb_l1_wb_loader.sv
// Directed bench for l1_wb_loader: a negedge Wishbone target model logs every
// access, and one linear initial block drives each scenario and checks it.
module tb_l1_wb_loader;

   localparam int NB = 2;
   localparam int TB = 18;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          wb_cyc_o, wb_stb_o, wb_we_o;
   logic [12:0]   wb_adr_o;
   logic [31:0]   wb_dat_o;
   logic [3:0]    wb_sel_o;
   logic          wb_ack_i = 1'b0, wb_err_i = 1'b0, wb_rty_i = 1'b0;
   logic [31:0]   wb_dat_i = 32'h0;
   logic          load_start_i = 1'b0, scal_start_i = 1'b0;
   logic [2*TB-1:0] thr_tdata_i = '0;
   logic          thr_tvalid_i = 1'b0;
   logic          thr_tready_o;
   logic [31:0]   scal_tdata_o;
   logic          scal_tuser_o, scal_tlast_o, scal_tvalid_o;
   logic          scal_tready_i = 1'b0;
   logic          busy_o, done_o, err_o;

   l1_wb_loader #(.NBEAMS(NB), .THRESH_BITS(TB), .TIMEOUT(255)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
      .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
      .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i), .wb_dat_i(wb_dat_i),
      .load_start_i(load_start_i), .scal_start_i(scal_start_i),
      .thr_tdata_i(thr_tdata_i), .thr_tvalid_i(thr_tvalid_i), .thr_tready_o(thr_tready_o),
      .scal_tdata_o(scal_tdata_o), .scal_tuser_o(scal_tuser_o), .scal_tlast_o(scal_tlast_o),
      .scal_tvalid_o(scal_tvalid_o), .scal_tready_i(scal_tready_i),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- target model / monitor ----------------
   // Target knobs, written only by the initial block.
   logic          hang_en = 1'b0;
   logic [12:0]   hang_adr = 13'h0;
   logic [12:0]   rty_adr = 13'h0;
   int            rty_limit = 0;
   logic [31:0]   rd_tab [4];

   // Monitor state, written only here.
   logic [45:0]   got_q [$];
   logic [33:0]   beat_q [$];
   int            rty_used = 0, done_cnt = 0, gap_viol = 0, bus_viol = 0;
   int            cur_len = 0, last_len = 0, idle_len = 1;
   logic          in_cyc = 1'b0;

   always @(negedge clk) begin
      wb_ack_i = 1'b0;
      wb_rty_i = 1'b0;
      wb_err_i = 1'b0;
      wb_dat_i = 32'h0;
      if (done_o) done_cnt++;
      if (scal_tvalid_o && scal_tready_i)
         beat_q.push_back({scal_tuser_o, scal_tlast_o, scal_tdata_o});
      if (wb_cyc_o) begin
         if (!in_cyc) begin
            in_cyc = 1'b1;
            cur_len = 0;
            if (idle_len < 1) gap_viol++;
            got_q.push_back({wb_we_o, wb_adr_o, wb_we_o ? wb_dat_o : 32'h0});
         end
         cur_len++;
         if (wb_sel_o !== 4'hF || wb_stb_o !== 1'b1) bus_viol++;
         if (hang_en && wb_adr_o == hang_adr) begin
            // no response
         end else if (rty_used < rty_limit && wb_adr_o == rty_adr) begin
            wb_rty_i = 1'b1;
            rty_used++;
         end else if (!wb_we_o) begin
            wb_ack_i = 1'b1;
            wb_dat_i = rd_tab[{wb_adr_o[9], wb_adr_o[2]}];
         end else begin
            wb_ack_i = 1'b1;
         end
      end else begin
         if (in_cyc) begin
            last_len = cur_len;
            in_cyc = 1'b0;
            idle_len = 0;
         end
         idle_len++;
      end
   end

   // ---------------- scoreboard ----------------
   logic [45:0]   exp_q [$];
   logic [33:0]   exp_beat_q [$];
   int            txn_ptr = 0, beat_ptr = 0;
   int            errors = 0, checks = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [45:0] txn(input logic we, input logic [12:0] adr, input logic [31:0] dat);
      return {we, adr, dat};
   endfunction

   task automatic check_txns(input string tag);
      int n;
      n = got_q.size() - txn_ptr;
      chk({tag, "_count"}, 64'(n), 64'(exp_q.size()));
      while (exp_q.size() > 0) begin
         if (txn_ptr < got_q.size()) begin
            chk({tag, "_txn"}, 64'(got_q[txn_ptr]), 64'(exp_q[0]));
            txn_ptr++;
         end
         void'(exp_q.pop_front());
      end
      txn_ptr = got_q.size();
   endtask

   task automatic check_beats(input string tag);
      chk({tag, "_beats"}, 64'(beat_q.size() - beat_ptr), 64'(exp_beat_q.size()));
      while (exp_beat_q.size() > 0) begin
         if (beat_ptr < beat_q.size()) begin
            chk({tag, "_beat"}, 64'(beat_q[beat_ptr]), 64'(exp_beat_q[0]));
            beat_ptr++;
         end
         void'(exp_beat_q.pop_front());
      end
      beat_ptr = beat_q.size();
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_load();
      load_start_i = 1'b1;
      tick();
      load_start_i = 1'b0;
   endtask

   task automatic send_pair(input logic [TB-1:0] sub, input logic [TB-1:0] thr);
      int   n;
      logic ok;
      n = 0;
      ok = 1'b0;
      thr_tdata_i  = {sub, thr};
      thr_tvalid_i = 1'b1;
      while (!ok && n < 100) begin
         ok = thr_tready_o;
         tick();
         n++;
      end
      thr_tvalid_i = 1'b0;
      chk("thr_handshake", 64'(ok), 64'd1);
   endtask

   task automatic wait_idle(input int bound);
      int n;
      n = 0;
      while (busy_o && n < bound) begin
         tick();
         n++;
      end
      chk("idle_reached", 64'(busy_o), 64'd0);
      tick();
      tick();
   endtask

   task automatic accept_beat(input int hold, input logic [31:0] data);
      int n;
      n = 0;
      while (!scal_tvalid_o && n < 100) begin
         tick();
         n++;
      end
      chk("beat_valid", 64'(scal_tvalid_o), 64'd1);
      for (int k = 0; k < hold; k++) begin
         tick();
         chk("stall_valid", 64'(scal_tvalid_o), 64'd1);
         chk("stall_data", 64'(scal_tdata_o), 64'(data));
         chk("stall_no_wb", 64'(wb_cyc_o), 64'd0);
      end
      scal_tready_i = 1'b1;
      tick();
      scal_tready_i = 1'b0;
   endtask

   task automatic expect_load(input logic [31:0] s0, input logic [31:0] t0,
                              input logic [31:0] s1, input logic [31:0] t1);
      exp_q.push_back(txn(1'b1, 13'h0800, t0));
      exp_q.push_back(txn(1'b1, 13'h0A00, s0));
      exp_q.push_back(txn(1'b1, 13'h0804, t1));
      exp_q.push_back(txn(1'b1, 13'h0A04, s1));
      exp_q.push_back(txn(1'b1, 13'h1800, 32'h3));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      int d0, n;
      rd_tab[0] = 32'd11;
      rd_tab[1] = 32'd22;
      rd_tab[2] = 32'd33;
      rd_tab[3] = 32'd44;

      // reset state
      #1 rst = 1'b1;
      repeat (3) tick();
      chk("rst_cyc", 64'(wb_cyc_o), 64'd0);
      chk("rst_sel", 64'(wb_sel_o), 64'd0);
      chk("rst_adr", 64'(wb_adr_o), 64'd0);
      chk("rst_tready", 64'(thr_tready_o), 64'd0);
      chk("rst_tvalid", 64'(scal_tvalid_o), 64'd0);
      chk("rst_busy", 64'(busy_o), 64'd0);
      chk("rst_done", 64'(done_o), 64'd0);
      chk("rst_err", 64'(err_o), 64'd0);
      rst = 1'b0;
      tick();

      // 1: plain load
      d0 = done_cnt;
      pulse_load();
      send_pair(18'd5, 18'd100);
      send_pair(18'd6, 18'd200);
      wait_idle(200);
      expect_load(32'd5, 32'd100, 32'd6, 32'd200);
      check_txns("load");
      chk("load_done", 64'(done_cnt - d0), 64'd1);
      chk("load_err", 64'(err_o), 64'd0);

      // 2: dump with a stall on beat 2
      d0 = done_cnt;
      scal_start_i = 1'b1;
      tick();
      scal_start_i = 1'b0;
      accept_beat(0, 32'd11);
      accept_beat(5, 32'd22);
      accept_beat(0, 32'd33);
      accept_beat(0, 32'd44);
      wait_idle(100);
      exp_q.push_back(txn(1'b0, 13'h0400, 32'h0));
      exp_q.push_back(txn(1'b0, 13'h0404, 32'h0));
      exp_q.push_back(txn(1'b0, 13'h0600, 32'h0));
      exp_q.push_back(txn(1'b0, 13'h0604, 32'h0));
      check_txns("dump");
      exp_beat_q.push_back({1'b0, 1'b0, 32'd11});
      exp_beat_q.push_back({1'b0, 1'b0, 32'd22});
      exp_beat_q.push_back({1'b1, 1'b0, 32'd33});
      exp_beat_q.push_back({1'b1, 1'b1, 32'd44});
      check_beats("dump");
      chk("dump_done", 64'(done_cnt - d0), 64'd1);

      // 3: 0x0804 never acked -> timeout abort, no commit
      d0 = done_cnt;
      hang_en = 1'b1;
      hang_adr = 13'h0804;
      pulse_load();
      send_pair(18'd5, 18'd100);
      send_pair(18'd6, 18'd200);
      wait_idle(600);
      chk("to_cyc_len", 64'(last_len), 64'd255);
      chk("to_err", 64'(err_o), 64'd1);
      chk("to_no_done", 64'(done_cnt - d0), 64'd0);
      exp_q.push_back(txn(1'b1, 13'h0800, 32'd100));
      exp_q.push_back(txn(1'b1, 13'h0A00, 32'd5));
      exp_q.push_back(txn(1'b1, 13'h0804, 32'd200));
      check_txns("timeout");
      hang_en = 1'b0;
      d0 = done_cnt;
      pulse_load();
      chk("err_cleared", 64'(err_o), 64'd0);
      send_pair(18'd7, 18'd300);
      send_pair(18'd8, 18'd400);
      wait_idle(200);
      expect_load(32'd7, 32'd300, 32'd8, 32'd400);
      check_txns("reload");
      chk("reload_done", 64'(done_cnt - d0), 64'd1);

      // 4: two retries on the first threshold write
      d0 = done_cnt;
      n = rty_used;
      rty_adr = 13'h0800;
      rty_limit = rty_used + 2;
      pulse_load();
      send_pair(18'd5, 18'd100);
      send_pair(18'd6, 18'd200);
      wait_idle(200);
      exp_q.push_back(txn(1'b1, 13'h0800, 32'd100));
      exp_q.push_back(txn(1'b1, 13'h0800, 32'd100));
      expect_load(32'd5, 32'd100, 32'd6, 32'd200);
      check_txns("retry");
      chk("retry_count", 64'(rty_used - n), 64'd2);
      chk("retry_done", 64'(done_cnt - d0), 64'd1);
      chk("retry_err", 64'(err_o), 64'd0);

      // 5: simultaneous starts, then a start while busy
      d0 = done_cnt;
      load_start_i = 1'b1;
      scal_start_i = 1'b1;
      tick();
      load_start_i = 1'b0;
      scal_start_i = 1'b0;
      tick();
      scal_start_i = 1'b1;
      tick();
      scal_start_i = 1'b0;
      send_pair(18'd1, 18'h3FFFF);
      send_pair(18'h20000, 18'd2);
      wait_idle(200);
      expect_load(32'd1, 32'h3FFFF, 32'h20000, 32'd2);
      check_txns("both_start");
      check_beats("both_start");
      chk("both_done", 64'(done_cnt - d0), 64'd1);

      // 6: asynchronous reset during TH_WR
      hang_en = 1'b1;
      hang_adr = 13'h0800;
      pulse_load();
      send_pair(18'd1, 18'd10);
      n = 0;
      while (!wb_cyc_o && n < 20) begin
         tick();
         n++;
      end
      chk("th_wr_cyc", 64'(wb_cyc_o), 64'd1);
      rst = 1'b1;
      #1;
      chk("arst_cyc", 64'(wb_cyc_o), 64'd0);
      chk("arst_busy", 64'(busy_o), 64'd0);
      tick();
      rst = 1'b0;
      hang_en = 1'b0;
      tick();
      txn_ptr = got_q.size();
      d0 = done_cnt;
      pulse_load();
      send_pair(18'd2, 18'd20);
      send_pair(18'd3, 18'd30);
      wait_idle(200);
      expect_load(32'd2, 32'd20, 32'd3, 32'd30);
      check_txns("post_rst");
      chk("post_rst_done", 64'(done_cnt - d0), 64'd1);

      chk("gap_violations", 64'(gap_viol), 64'd0);
      chk("bus_violations", 64'(bus_viol), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
